// File: rtl/ofs_asp_usm_host_arbiter.sv
// Round-robin arbiter sharing one USM host AVMM port between NUM_REQ requesters.
// Write bursts hold the grant until the last beat; read data is steered back in order via a tag FIFO.
module ofs_asp_usm_host_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int ADDR_WIDTH       = 48,
  parameter int DATA_WIDTH       = 512,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int BURST_MAX        = 16,
  parameter int TAG_FIFO_DEPTH   = 64
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]        i_req_address,
  input  logic [NUM_REQ-1:0]                   i_req_read,
  input  logic [NUM_REQ-1:0]                   i_req_write,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]        i_req_writedata,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0]      i_req_byteenable,
  input  logic [NUM_REQ*BURSTCOUNT_WIDTH-1:0]  i_req_burstcount,
  output logic [NUM_REQ-1:0]                   o_req_waitrequest,
  output logic [DATA_WIDTH-1:0]                o_req_readdata,
  output logic [NUM_REQ-1:0]                   o_req_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                o_host_address,
  output logic                                 o_host_read,
  output logic                                 o_host_write,
  output logic [DATA_WIDTH-1:0]                o_host_writedata,
  output logic [DATA_WIDTH/8-1:0]              o_host_byteenable,
  output logic [BURSTCOUNT_WIDTH-1:0]          o_host_burstcount,
  input  logic                                 i_host_waitrequest,
  input  logic [DATA_WIDTH-1:0]                i_host_readdata,
  input  logic                                 i_host_readdatavalid,
  output logic                                 o_err_unexpected_rsp
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (TAG_FIFO_DEPTH > 1) ? $clog2(TAG_FIFO_DEPTH) : 1;
  localparam int BE_W  = DATA_WIDTH / 8;

  localparam logic [IDX_W-1:0]            IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]            IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0]            IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ZERO  = {BURSTCOUNT_WIDTH{1'b0}};
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE   = BURSTCOUNT_WIDTH'(1);
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_MAX   = BURSTCOUNT_WIDTH'(BURST_MAX);
  localparam logic [PTR_W-1:0]            PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]            PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]              CNT_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]              CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]              CNT_FULL = (PTR_W+1)'(TAG_FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WR_BURST = 1'b1
  } state_t;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_LAST) begin
      next_idx = IDX_ZERO;
    end else begin
      next_idx = idx + IDX_ONE;
    end
  endfunction

  // Illegal burst lengths are issued to the host as single beats.
  function automatic logic [BURSTCOUNT_WIDTH-1:0] legal_bc(input logic [BURSTCOUNT_WIDTH-1:0] bc);
    if ((bc == BC_ZERO) || (bc > BC_MAX)) begin
      legal_bc = BC_ONE;
    end else begin
      legal_bc = bc;
    end
  endfunction

  logic [ADDR_WIDTH-1:0]       w_addr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]       w_wdata [NUM_REQ];
  logic [BE_W-1:0]             w_be    [NUM_REQ];
  logic [BURSTCOUNT_WIDTH-1:0] w_bc    [NUM_REQ];
  logic [NUM_REQ-1:0]          w_req;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_addr[g]  = i_req_address[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[g] = i_req_writedata[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_be[g]    = i_req_byteenable[g*BE_W +: BE_W];
    assign w_bc[g]    = i_req_burstcount[g*BURSTCOUNT_WIDTH +: BURSTCOUNT_WIDTH];
  end
  assign w_req = i_req_read | i_req_write;

  state_t                      r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_rr_ptr, w_rr_nxt;
  logic [IDX_W-1:0]            r_lock, w_lock_nxt;
  logic [BURSTCOUNT_WIDTH-1:0] r_beats_left, w_beats_nxt;
  logic [ADDR_WIDTH-1:0]       r_addr_hold, w_addr_hold_nxt;
  logic [BURSTCOUNT_WIDTH-1:0] r_bc_hold, w_bc_hold_nxt;

  logic [IDX_W-1:0]            r_tag_idx [TAG_FIFO_DEPTH];
  logic [BURSTCOUNT_WIDTH-1:0] r_tag_bc  [TAG_FIFO_DEPTH];
  logic [PTR_W-1:0]            r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]              r_count;
  logic [BURSTCOUNT_WIDTH-1:0] r_rsp_beats;
  logic [NUM_REQ-1:0]          r_rdv;
  logic [DATA_WIDTH-1:0]       r_rdata;
  logic                        r_err;

  logic [IDX_W-1:0]            w_grant, w_scan, w_sel, w_head_idx;
  logic                        w_any_req, w_host_read, w_host_write, w_accept;
  logic [BURSTCOUNT_WIDTH-1:0] w_bc_legal, w_head_bc;
  logic                        w_fifo_empty, w_fifo_full, w_push, w_pop, w_rsp_hit;
  logic [NUM_REQ-1:0]          w_rsp_onehot;

  // Round-robin scan: first requester at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant   = r_rr_ptr;
    w_any_req = 1'b0;
    w_scan    = r_rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_any_req && w_req[w_scan]) begin
        w_grant   = w_scan;
        w_any_req = 1'b1;
      end else begin
        w_any_req = w_any_req;
      end
      w_scan = next_idx(w_scan);
    end
  end

  assign w_sel        = (r_state == ST_IDLE) ? w_grant : r_lock;
  assign w_bc_legal   = legal_bc(w_bc[w_sel]);
  assign w_fifo_empty = (r_count == CNT_ZERO);
  assign w_fifo_full  = (r_count == CNT_FULL);
  assign w_head_idx   = r_tag_idx[r_rd_ptr];
  assign w_head_bc    = r_tag_bc[r_rd_ptr];
  assign w_rsp_hit    = i_host_readdatavalid && !w_fifo_empty;
  assign w_pop        = w_rsp_hit && ((r_rsp_beats + BC_ONE) == w_head_bc);

  // Command presentation; a full tag FIFO only blocks reads, and a same-cycle pop frees a slot.
  always_comb begin
    w_host_read  = 1'b0;
    w_host_write = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req && i_req_read[w_sel]) begin
          w_host_read  = !w_fifo_full || w_pop;
          w_host_write = 1'b0;
        end else begin
          w_host_read  = 1'b0;
          w_host_write = w_any_req;
        end
      end
      ST_WR_BURST: begin
        w_host_read  = 1'b0;
        w_host_write = i_req_write[r_lock];
      end
      default: begin
        w_host_read  = 1'b0;
        w_host_write = 1'b0;
      end
    endcase
  end

  assign o_host_read       = w_host_read && i_reset_n;
  assign o_host_write      = w_host_write && i_reset_n;
  assign w_accept          = (o_host_read || o_host_write) && !i_host_waitrequest;
  assign w_push            = w_accept && o_host_read;
  assign o_host_address    = (r_state == ST_IDLE) ? w_addr[w_sel] : r_addr_hold;
  assign o_host_burstcount = (r_state == ST_IDLE) ? w_bc_legal : r_bc_hold;
  assign o_host_writedata  = w_wdata[w_sel];
  assign o_host_byteenable = w_be[w_sel];

  // Per-requester stall: only the accepted requester sees waitrequest low.
  always_comb begin
    o_req_waitrequest = {NUM_REQ{1'b1}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_accept && (w_sel == IDX_W'(i))) begin
        o_req_waitrequest[i] = 1'b0;
      end else begin
        o_req_waitrequest[i] = 1'b1;
      end
    end
  end

  // Next-state logic for the arbitration FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_nxt        = r_rr_ptr;
    w_lock_nxt      = r_lock;
    w_beats_nxt     = r_beats_left;
    w_addr_hold_nxt = r_addr_hold;
    w_bc_hold_nxt   = r_bc_hold;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_host_write && (w_bc_legal != BC_ONE)) begin
          w_state_nxt     = ST_WR_BURST;
          w_lock_nxt      = w_grant;
          w_beats_nxt     = w_bc_legal - BC_ONE;
          w_addr_hold_nxt = w_addr[w_grant];
          w_bc_hold_nxt   = w_bc_legal;
        end else if (w_accept) begin
          w_rr_nxt = next_idx(w_grant);
        end else begin
          w_rr_nxt = r_rr_ptr;
        end
      end
      ST_WR_BURST: begin
        if (w_accept && (r_beats_left == BC_ONE)) begin
          w_state_nxt = ST_IDLE;
          w_rr_nxt    = next_idx(r_lock);
        end else if (w_accept) begin
          w_beats_nxt = r_beats_left - BC_ONE;
        end else begin
          w_beats_nxt = r_beats_left;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Arbitration FSM state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_IDLE;
      r_rr_ptr     <= IDX_ZERO;
      r_lock       <= IDX_ZERO;
      r_beats_left <= BC_ZERO;
      r_addr_hold  <= {ADDR_WIDTH{1'b0}};
      r_bc_hold    <= BC_ZERO;
    end else begin
      r_state      <= w_state_nxt;
      r_rr_ptr     <= w_rr_nxt;
      r_lock       <= w_lock_nxt;
      r_beats_left <= w_beats_nxt;
      r_addr_hold  <= w_addr_hold_nxt;
      r_bc_hold    <= w_bc_hold_nxt;
    end
  end

  // Tag FIFO storage: {requester, burstcount} per accepted read.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_tag_idx[r_wr_ptr] <= w_sel;
      r_tag_bc[r_wr_ptr]  <= w_bc_legal;
    end
  end

  // Tag FIFO pointers and occupancy.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= PTR_ZERO;
      r_rd_ptr <= PTR_ZERO;
      r_count  <= CNT_ZERO;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Steering vector for the FIFO head requester.
  always_comb begin
    w_rsp_onehot = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_head_idx == IDX_W'(i)) begin
        w_rsp_onehot[i] = 1'b1;
      end else begin
        w_rsp_onehot[i] = 1'b0;
      end
    end
  end

  // Registered response path, beat counting and sticky error.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rsp_beats <= BC_ZERO;
      r_rdv       <= {NUM_REQ{1'b0}};
      r_rdata     <= {DATA_WIDTH{1'b0}};
      r_err       <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rsp_beats <= BC_ZERO;
      end else if (w_rsp_hit) begin
        r_rsp_beats <= r_rsp_beats + BC_ONE;
      end
      r_rdv <= w_rsp_hit ? w_rsp_onehot : {NUM_REQ{1'b0}};
      if (i_host_readdatavalid) begin
        r_rdata <= i_host_readdata;
      end
      if (i_host_readdatavalid && w_fifo_empty) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_req_readdatavalid  = r_rdv;
  assign o_req_readdata       = r_rdata;
  assign o_err_unexpected_rsp = r_err;

endmodule

// File: tb/tb_ofs_asp_usm_host_arbiter.sv
// Bench for ofs_asp_usm_host_arbiter: table of arbitration vectors, directed corner sequences,
// and a response scoreboard that expects each host beat on the issuing requester one cycle later.
module tb_ofs_asp_usm_host_arbiter;
  localparam int NR  = 2;
  localparam int AW  = 48;
  localparam int DW  = 32;
  localparam int BCW = 5;
  localparam int BEW = DW / 8;
  localparam logic [AW-1:0] A0 = 48'h1000;
  localparam logic [AW-1:0] A1 = 48'h2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [NR-1:0]   rd, wr;
  logic [AW-1:0]   addr  [NR];
  logic [DW-1:0]   wdata [NR];
  logic [BCW-1:0]  bc    [NR];
  logic            host_wait, host_rdv;
  logic [DW-1:0]   host_rdata;

  logic [NR-1:0]   wreq, rdv;
  logic [DW-1:0]   rdata, h_wdata;
  logic [AW-1:0]   h_addr;
  logic            h_read, h_write, err;
  logic [BEW-1:0]  h_be;
  logic [BCW-1:0]  h_bc;

  ofs_asp_usm_host_arbiter #(
    .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURSTCOUNT_WIDTH(BCW),
    .BURST_MAX(16), .TAG_FIFO_DEPTH(64)
  ) dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_req_address({addr[1], addr[0]}), .i_req_read(rd), .i_req_write(wr),
    .i_req_writedata({wdata[1], wdata[0]}), .i_req_byteenable({2*BEW{1'b1}}),
    .i_req_burstcount({bc[1], bc[0]}),
    .o_req_waitrequest(wreq), .o_req_readdata(rdata), .o_req_readdatavalid(rdv),
    .o_host_address(h_addr), .o_host_read(h_read), .o_host_write(h_write),
    .o_host_writedata(h_wdata), .o_host_byteenable(h_be), .o_host_burstcount(h_bc),
    .i_host_waitrequest(host_wait), .i_host_readdata(host_rdata),
    .i_host_readdatavalid(host_rdv), .o_err_unexpected_rsp(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int idx; logic [DW-1:0] data; int due; } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  // Scoreboard: each expected beat must appear on its requester exactly at its due cycle.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (rdv !== (2'b01 << mon_e.idx) || rdata !== mon_e.data) begin
        failures++;
        $display("FAIL rsp_route cyc=%0d got rdv=%b data=%h expected rdv=%b data=%h",
                 cyc, rdv, rdata, 2'b01 << mon_e.idx, mon_e.data);
      end
    end else if (rdv !== 2'b00) begin
      checks++;
      failures++;
      $display("FAIL rsp_spurious cyc=%0d got rdv=%b expected 00", cyc, rdv);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    host_rdv = 1'b0;
  endtask

  task automatic host_beat(input int idx);
    host_rdata = $urandom;
    host_rdv   = 1'b1;
    sb.push_back('{idx, host_rdata, cyc + 1});
  endtask

  typedef struct {
    logic [1:0] rd, wr; logic [4:0] bc0, bc1; logic hwait;
    logic chk_cmd, hr, hw; logic [AW-1:0] addr; logic [4:0] hbc; logic [1:0] wreq;
  } vec_t;
  vec_t tbl [10];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{2'b00, 2'b00, 5'd1,  5'd1, 1'b0, 1'b0, 1'b0, 1'b0, A0, 5'd1, 2'b11};
    tbl[1] = '{2'b11, 2'b00, 5'd1,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0, A0, 5'd1, 2'b10};
    tbl[2] = '{2'b11, 2'b00, 5'd1,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0, A1, 5'd1, 2'b01};
    tbl[3] = '{2'b11, 2'b00, 5'd1,  5'd1, 1'b1, 1'b1, 1'b1, 1'b0, A0, 5'd1, 2'b11};
    tbl[4] = '{2'b01, 2'b00, 5'd1,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0, A0, 5'd1, 2'b10};
    tbl[5] = '{2'b01, 2'b00, 5'd1,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0, A0, 5'd1, 2'b10};
    tbl[6] = '{2'b00, 2'b10, 5'd1,  5'd1, 1'b0, 1'b1, 1'b0, 1'b1, A1, 5'd1, 2'b01};
    tbl[7] = '{2'b01, 2'b01, 5'd1,  5'd1, 1'b0, 1'b1, 1'b1, 1'b0, A0, 5'd1, 2'b10};
    tbl[8] = '{2'b00, 2'b11, 5'd1,  5'd0, 1'b0, 1'b1, 1'b0, 1'b1, A1, 5'd1, 2'b01};
    tbl[9] = '{2'b00, 2'b01, 5'd20, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, A0, 5'd1, 2'b10};

    addr[0] = A0; addr[1] = A1;
    wdata[0] = 32'hA0A0_0000; wdata[1] = 32'hB1B1_0000;
    bc[0] = 5'd1; bc[1] = 5'd1;
    host_wait = 1'b0; host_rdv = 1'b0; host_rdata = 32'h0;

    // Reset with both requesters active: nothing may reach the host.
    reset_n = 1'b0; rd = 2'b11; wr = 2'b11;
    #12;
    chk("rst_host_read", h_read, 1'b0);
    chk("rst_host_write", h_write, 1'b0);
    chk("rst_waitreq", wreq, 2'b11);
    chk("rst_rdv", rdv, 2'b00);
    chk("rst_err", err, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b1; rd = 2'b00; wr = 2'b00;

    // Table: round-robin order, stalls, read priority and illegal burst lengths.
    for (int i = 0; i < 10; i++) begin
      rd = tbl[i].rd; wr = tbl[i].wr; bc[0] = tbl[i].bc0; bc[1] = tbl[i].bc1;
      host_wait = tbl[i].hwait;
      #1;
      chk($sformatf("vec%0d_read", i), h_read, tbl[i].hr);
      chk($sformatf("vec%0d_write", i), h_write, tbl[i].hw);
      chk($sformatf("vec%0d_waitreq", i), wreq, tbl[i].wreq);
      if (tbl[i].chk_cmd) begin
        chk($sformatf("vec%0d_addr", i), h_addr, tbl[i].addr);
        chk($sformatf("vec%0d_bc", i), h_bc, tbl[i].hbc);
      end
      tick();
    end
    rd = 2'b00; wr = 2'b00; bc[0] = 5'd1; bc[1] = 5'd1; host_wait = 1'b0;
    host_beat(0); tick(); host_beat(1); tick(); host_beat(0); tick();
    host_beat(0); tick(); host_beat(0); tick(); tick();

    // Write burst of 4 from req1 locks out req0's continuous read, including across a stall.
    rd = 2'b01; wr = 2'b10; bc[1] = 5'd4;
    for (int b = 0; b < 5; b++) begin
      wdata[1] = 32'hB1B1_0000 + b;
      host_wait = (b == 2);
      if (b == 1) begin addr[1] = 48'h2FC0; bc[1] = 5'd9; end
      #1;
      chk($sformatf("wb%0d_write", b), h_write, 1'b1);
      chk($sformatf("wb%0d_read", b), h_read, 1'b0);
      chk($sformatf("wb%0d_addr", b), h_addr, A1);
      chk($sformatf("wb%0d_bc", b), h_bc, 5'd4);
      chk($sformatf("wb%0d_wdata", b), h_wdata, 32'hB1B1_0000 + b);
      chk($sformatf("wb%0d_waitreq", b), wreq, (b == 2) ? 2'b11 : 2'b01);
      tick();
    end
    host_wait = 1'b0; wr = 2'b00; addr[1] = A1; bc[1] = 5'd1;
    #1;
    chk("wb_after_read", h_read, 1'b1);
    chk("wb_after_waitreq", wreq, 2'b10);
    tick();
    rd = 2'b00;
    host_beat(0); tick(); tick();

    // Fill the tag FIFO with 64 single reads from req0.
    for (int i = 0; i < 64; i++) begin
      rd = 2'b01;
      #1;
      chk("fill_waitreq", wreq, 2'b10);
      tick();
    end
    #1;
    chk("full_read_blocked", h_read, 1'b0);
    chk("full_waitreq", wreq, 2'b11);
    tick();
    wr = 2'b10;
    #1;
    chk("full_write_ok", h_write, 1'b1);
    chk("full_write_noread", h_read, 1'b0);
    chk("full_write_waitreq", wreq, 2'b01);
    tick();
    wr = 2'b00;
    host_beat(0);
    #1;
    chk("full_pop_read", h_read, 1'b1);
    chk("full_pop_waitreq", wreq, 2'b10);
    tick();
    rd = 2'b00;
    for (int i = 0; i < 64; i++) begin
      host_beat(0); tick();
    end
    tick();

    // Read burst 16 from req0 then burst 2 from req1.
    rd = 2'b01; bc[0] = 5'd16;
    #1;
    chk("rb16_read", h_read, 1'b1);
    chk("rb16_bc", h_bc, 5'd16);
    chk("rb16_waitreq", wreq, 2'b10);
    tick();
    rd = 2'b10; bc[1] = 5'd2;
    #1;
    chk("rb2_read", h_read, 1'b1);
    chk("rb2_bc", h_bc, 5'd2);
    chk("rb2_waitreq", wreq, 2'b01);
    tick();
    rd = 2'b00; bc[0] = 5'd1; bc[1] = 5'd1;
    for (int i = 0; i < 18; i++) begin
      host_beat((i < 16) ? 0 : 1); tick();
    end
    tick(); tick();
    chk("err_before_stray", err, 1'b0);

    // Stray response with nothing outstanding.
    host_rdata = 32'hDEAD_BEEF; host_rdv = 1'b1;
    tick();
    chk("stray_err", err, 1'b1);
    chk("stray_no_rdv", rdv, 2'b00);
    tick(); tick(); tick();
    chk("stray_err_held", err, 1'b1);

    // Reset in the middle of an 8-beat write burst from req1 (rr_ptr is 1 beforehand).
    rd = 2'b01;
    tick();
    rd = 2'b00; wr = 2'b10; bc[1] = 5'd8;
    #1;
    chk("rstb_beat1_write", h_write, 1'b1);
    chk("rstb_beat1_waitreq", wreq, 2'b01);
    tick();
    #1;
    chk("rstb_beat2_write", h_write, 1'b1);
    chk("rstb_beat2_waitreq", wreq, 2'b01);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rstb_write_low", h_write, 1'b0);
    chk("rstb_read_low", h_read, 1'b0);
    chk("rstb_waitreq", wreq, 2'b11);
    chk("rstb_err_clear", err, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    rd = 2'b01; wr = 2'b10;
    #1;
    chk("post_rst_read", h_read, 1'b1);
    chk("post_rst_write", h_write, 1'b0);
    chk("post_rst_waitreq", wreq, 2'b10);
    tick();
    rd = 2'b00; wr = 2'b00;
    tick(); tick();

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
